// File: rtl/ysyx_22041211_mem_arb.sv
// ysyx_22041211_mem_arb: IFU/LSU arbiter onto one valid/ready memory port with a response watchdog.
// Define YSYX_22041211_ARB_RR_EN for round-robin grant on contention; otherwise the LSU has fixed priority.
module ysyx_22041211_mem_arb #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32,
    parameter int TIMEOUT  = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_LEN-1:0] ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_LEN-1:0] ifu_rdata,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_LEN-1:0] lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_LEN-1:0] lsu_wdata,
    input  logic [3:0]          lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_LEN-1:0] lsu_rdata,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                mem_wen,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic [3:0]          mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_LEN-1:0] mem_rdata,
    output logic                owner,
    output logic                timeout_err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic       pick_lsu, grant_lsu, grant_ifu, expire, done;
    always_comb begin
`ifdef YSYX_22041211_ARB_RR_EN
        pick_lsu = ~owner;
`else
        pick_lsu = 1'b1;
`endif
        grant_lsu      = lsu_req_valid & (~ifu_req_valid | pick_lsu);
        grant_ifu      = ifu_req_valid & ~grant_lsu;
        ifu_req_ready  = rst & (state == IDLE) & grant_ifu;
        lsu_req_ready  = rst & (state == IDLE) & grant_lsu;
        mem_req_valid  = state == ISSUE;
        expire         = (state == WAIT) & (cnt == 8'(TIMEOUT));
        done           = (state == WAIT) & (mem_resp_valid | expire);
        ifu_resp_valid = done & ~owner;
        lsu_resp_valid = done & owner;
        // a forced completion returns zero data; real data wins on the expiry cycle
        ifu_rdata      = (ifu_resp_valid & mem_resp_valid) ? mem_rdata : '0;
        lsu_rdata      = (lsu_resp_valid & mem_resp_valid) ? mem_rdata : '0;
        state_nxt      = (state == IDLE)  ? ((ifu_req_ready | lsu_req_ready) ? ISSUE : IDLE) :
                         (state == ISSUE) ? (mem_req_ready ? WAIT : ISSUE) :
                         (state == WAIT)  ? (done ? IDLE : WAIT) : IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            timeout_err <= 1'b0;
            cnt         <= '0;
            mem_addr    <= '0;
            mem_wen     <= 1'b0;
            mem_wdata   <= '0;
            mem_wmask   <= '0;
        end else begin
            state <= state_nxt;
            if (ifu_req_ready | lsu_req_ready) begin
                owner     <= lsu_req_ready;
                mem_addr  <= lsu_req_ready ? lsu_addr : ifu_addr;
                mem_wen   <= lsu_req_ready & lsu_wen;
                mem_wdata <= lsu_req_ready ? lsu_wdata : '0;
                mem_wmask <= lsu_req_ready ? lsu_wmask : 4'h0;
            end
            if ((state == ISSUE) & mem_req_ready)
                cnt <= '0;
            else if ((state == WAIT) & ~done)
                cnt <= cnt + 8'd1;
            if (expire & ~mem_resp_valid)
                timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ysyx_22041211_mem_arb.sv
// tb_ysyx_22041211_mem_arb: directed self-checking bench for the IFU/LSU memory arbiter (TIMEOUT=8).
module tb_ysyx_22041211_mem_arb;
    logic        clk = 1'b0, rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [3:0]  lsu_wmask, mem_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, owner, timeout_err;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    int          n_chk = 0, n_pass = 0;
    logic        exp_lsu;
    ysyx_22041211_mem_arb #(.ADDR_LEN(32), .DATA_LEN(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
        .owner(owner), .timeout_err(timeout_err)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    initial begin
        rst = 1'b0;
        {ifu_req_valid, lsu_req_valid, lsu_wen, mem_req_ready, mem_resp_valid} = '0;
        {ifu_addr, lsu_addr, lsu_wdata, mem_rdata} = '0;
        lsu_wmask = 4'h0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        #2;
        check("rst_ifu_ready", ifu_req_ready, 0);
        check("rst_lsu_ready", lsu_req_ready, 0);
        check("rst_mem_valid", mem_req_valid, 0);
        check("rst_owner", owner, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_mem_addr", mem_addr, 0);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        // LSU write under backpressure, IFU asking the whole time
        tick();
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_1000; lsu_wen = 1'b1;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF; ifu_req_valid = 1'b1;
        #1;
        check("wr_lsu_ready", lsu_req_ready, 1);
        check("wr_ifu_ready", ifu_req_ready, 0);
        tick();
        lsu_req_valid = 1'b0; lsu_addr = 32'h0; lsu_wen = 1'b0; lsu_wdata = 32'h0; lsu_wmask = 4'h0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_mem_valid", mem_req_valid, 1);
            check("bp_mem_addr", mem_addr, 32'h8000_1000);
            check("bp_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
            check("bp_mem_wmask", mem_wmask, 4'hF);
            check("bp_mem_wen", mem_wen, 1);
            check("bp_ifu_ready", ifu_req_ready, 0);
            tick();
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        check("wr_wait_ifu_ready", ifu_req_ready, 0);
        check("wr_wait_no_resp", lsu_resp_valid, 0);
        check("wr_wait_mem_valid", mem_req_valid, 0);
        tick();
        mem_resp_valid = 1'b1;
        #1;
        check("wr_lsu_resp", lsu_resp_valid, 1);
        check("wr_ifu_resp", ifu_resp_valid, 0);
        check("wr_owner", owner, 1);
        check("wr_resp_ifu_ready", ifu_req_ready, 0);
        ifu_req_valid = 1'b0;
        tick();
        mem_resp_valid = 1'b0;
        // single IFU read, 3-cycle turnaround
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0000;
        #1;
        check("rd_ifu_ready", ifu_req_ready, 1);
        check("rd_lsu_ready", lsu_req_ready, 0);
        tick();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        #1;
        check("rd_mem_valid", mem_req_valid, 1);
        check("rd_mem_addr", mem_addr, 32'h8000_0000);
        check("rd_mem_wen", mem_wen, 0);
        check("rd_mem_wmask", mem_wmask, 0);
        check("rd_owner", owner, 0);
        tick();
        mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h0000_0413;
        #1;
        check("rd_ifu_resp", ifu_resp_valid, 1);
        check("rd_ifu_rdata", ifu_rdata, 32'h0000_0413);
        check("rd_lsu_resp", lsu_resp_valid, 0);
        check("rd_lsu_rdata", lsu_rdata, 0);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        check("rd_resp_pulse", ifu_resp_valid, 0);
        check("rd_back_idle", mem_req_valid, 0);
        // contention: both masters request continuously for 4 transactions
        ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; lsu_wen = 1'b0;
        for (int i = 0; i < 4; i++) begin
`ifdef YSYX_22041211_ARB_RR_EN
            exp_lsu = (i % 2) == 0;
`else
            exp_lsu = 1'b1;
`endif
            #1;
            check("ct_lsu_ready", lsu_req_ready, exp_lsu);
            check("ct_ifu_ready", ifu_req_ready, !exp_lsu);
            tick();
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_rdata = 32'h100 + i;
            #1;
            check("ct_owner", owner, exp_lsu);
            check("ct_lsu_resp", lsu_resp_valid, exp_lsu);
            check("ct_ifu_resp", ifu_resp_valid, !exp_lsu);
            check("ct_rdata", exp_lsu ? lsu_rdata : ifu_rdata, 32'h100 + i);
            tick();
            mem_resp_valid = 1'b0;
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
        // response arrives on the expiry cycle: real data wins
        #1;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
        tick();
        ifu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        repeat (8) tick();
        mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
        #1;
        check("co_ifu_resp", ifu_resp_valid, 1);
        check("co_ifu_rdata", ifu_rdata, 32'h1234_5678);
        tick();
        mem_resp_valid = 1'b0;
        #1;
        check("co_timeout_err", timeout_err, 0);
        check("co_idle", mem_req_valid, 0);
        // watchdog expiry with a silent memory
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_2000;
        tick();
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            #1;
            check("to_quiet", lsu_resp_valid, 0);
            tick();
        end
        #1;
        check("to_lsu_resp", lsu_resp_valid, 1);
        check("to_lsu_rdata", lsu_rdata, 0);
        check("to_ifu_resp", ifu_resp_valid, 0);
        check("to_err_not_yet", timeout_err, 0);
        tick();
        #1;
        check("to_err_set", timeout_err, 1);
        check("to_resp_pulse", lsu_resp_valid, 0);
        check("to_idle", mem_req_valid, 0);
        lsu_req_valid = 1'b1; lsu_addr = 32'h8000_3000;
        #1;
        check("to_next_ready", lsu_req_ready, 1);
        tick();
        lsu_req_valid = 1'b0; mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        #1;
        check("to_err_sticky", timeout_err, 1);
        // reset while in WAIT abandons the transaction
        rst = 1'b0;
        #1;
        check("rw_owner", owner, 0);
        check("rw_timeout_err", timeout_err, 0);
        check("rw_mem_addr", mem_addr, 0);
        check("rw_mem_valid", mem_req_valid, 0);
        mem_resp_valid = 1'b1; mem_rdata = 32'hCAFE_F00D;
        #1;
        check("rw_lsu_resp", lsu_resp_valid, 0);
        check("rw_lsu_rdata", lsu_rdata, 0);
        tick();
        #2 rst = 1'b1;
        #1;
        check("rw_idle_drop_lsu", lsu_resp_valid, 0);
        check("rw_idle_drop_ifu", ifu_resp_valid, 0);
        tick();
        mem_resp_valid = 1'b0;
        ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0100;
        #1;
        check("rw_ifu_ready", ifu_req_ready, 1);
        tick();
        ifu_req_valid = 1'b0;
        #1;
        check("rw_mem_valid_new", mem_req_valid, 1);
        check("rw_mem_addr_new", mem_addr, 32'h8000_0100);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ysyx_22041211_mem_arb.md
# ysyx_22041211_mem_arb

Two-master memory arbiter for the single-port core. It lets the instruction fetch unit (IFU) and the load/store unit (LSU) share one physical memory port. It accepts one request at a time, forwards it to memory over a valid/ready handshake, and routes the response back to the master that owns the transaction. A watchdog counter ends any transaction the memory never answers.

## Interface
Parameters:
- ADDR_LEN, 32, address width
- DATA_LEN, 32, data width
- TIMEOUT, 255, maximum WAIT cycles before forced completion (1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- ifu_req_valid  in  1  IFU read request
- ifu_req_ready  out  1  IFU request accepted
- ifu_addr  in  ADDR_LEN  IFU read address
- ifu_resp_valid  out  1  IFU read data valid (single-cycle pulse)
- ifu_rdata  out  DATA_LEN  IFU read data
- lsu_req_valid  in  1  LSU request
- lsu_req_ready  out  1  LSU request accepted
- lsu_addr  in  ADDR_LEN  LSU address
- lsu_wen  in  1  1 = write, 0 = read
- lsu_wdata  in  DATA_LEN  write data
- lsu_wmask  in  4  byte write mask
- lsu_resp_valid  out  1  LSU completion pulse (reads and writes)
- lsu_rdata  out  DATA_LEN  LSU read data
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts the request
- mem_addr, mem_wen, mem_wdata, mem_wmask  out  ADDR_LEN/1/DATA_LEN/4  latched request fields
- mem_resp_valid  in  1  memory response
- mem_rdata  in  DATA_LEN  memory read data
- owner  out  1  0 = IFU, 1 = LSU; owner of the current or last transaction
- timeout_err  out  1  sticky; set on any watchdog expiry

## Operation
- FSM states: IDLE, ISSUE, WAIT.
- IDLE
  - Grant is combinational: *_req_ready = (state==IDLE) & grant_to_that_master. The other master's ready is 0.
  - On valid & ready: latch addr, wen, wdata and wmask into the mem_* registers. IFU requests latch wen=0 and wmask=0. Update owner, then go to ISSUE.
- ISSUE
  - mem_req_valid=1. The mem_* fields stay stable until mem_req_ready=1.
  - On mem_req_ready, go to WAIT.
  - mem_resp_valid is ignored in ISSUE.
- WAIT
  - On mem_resp_valid, the owner's resp_valid=1 for that cycle, combinationally. Its rdata = mem_rdata; the non-owner's rdata is 0. Go to IDLE.
  - Writes also complete on mem_resp_valid; lsu_rdata is don't-care for writes.
- Watchdog
  - An 8-bit counter is cleared on entry to WAIT and increments each WAIT cycle with no response.
  - When the counter reaches TIMEOUT: assert the owner's resp_valid with rdata=0, set timeout_err, go to IDLE.
  - If mem_resp_valid arrives in that same cycle, the real data wins and timeout_err is not set.
- Masters must accept responses unconditionally; there is no response backpressure.
- Any response from memory while in IDLE is dropped.
- Reset
  - Async assertion forces: state=IDLE, owner=0, timeout_err=0, counter=0, all mem_* registers 0.
  - All outputs read 0 during reset.
  - A reset in the middle of a transaction abandons it silently; no resp_valid is produced.

## Timing
- Request accepted in cycle N. mem_req_valid is high from N+1.
- With mem_req_ready=1 in N+1, the earliest response is N+2. The next request can be accepted in N+3.
- The minimum cost is 3 cycles per transaction. There is no overlap or pipelining; the block has one outstanding transaction at most.
- ready depends only on state, the registered last-owner bit and the request valids. There is no combinational path from mem_* to *_req_ready.
- Only resp_valid and rdata are combinational from mem_resp_valid and mem_rdata.

## Configuration
- Macro YSYX_22041211_ARB_RR_EN selects the grant policy when both masters request in the same IDLE cycle.
- Defined: round-robin. The master that was not the previous owner wins. The first contention after reset goes to the LSU, because owner resets to 0.
- Undefined: fixed priority; the LSU always wins.
- A single request is granted immediately under either policy.

## Test plan
- Single IFU read: ifu addr 0x80000000, memory ready immediately, responds 1 cycle later with 0x00000413 -> ifu_resp_valid one cycle, ifu_rdata=0x00000413, lsu_resp_valid=0, 3-cycle turnaround.
- LSU write under backpressure: lsu addr 0x80001000, wdata 0xDEADBEEF, wmask 0xF, mem_req_ready low 4 cycles -> mem_* fields stable throughout, lsu_resp_valid after the response, ifu_req_ready=0 the whole time.
- Contention: both request continuously for 4 transactions -> without the macro, LSU served 4 times; with it, order is LSU, IFU, LSU, IFU.
- Timeout: TIMEOUT=8, memory never responds -> owner's resp_valid exactly 8 WAIT cycles after entry, rdata=0, timeout_err=1 and stays 1, next request accepted.
- Response on the expiry cycle: mem_resp_valid coincides with counter==TIMEOUT and data 0x12345678 -> rdata=0x12345678, timeout_err stays 0.
- Reset in WAIT: drop rst to 0 while in WAIT -> outputs 0 immediately. After release, no resp_valid, and IDLE accepts a new IFU request.
